// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package mem_arb_pkg;

    // Arbiter sequencing states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // Owner of the access in flight.
    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    // Access sizes, encoded as funct3[1:0].
    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    // Bits needed to hold a count of 0..max_val, never less than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// Combinational priority picker: data wins unless fetch has waited out
// STARVE_MAX consecutive data grants. Outputs are one-hot or zero.
module mem_arb_grant #(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 3
) (
    input  logic             if_valid,
    input  logic             d_valid,
    input  logic [CNT_W-1:0] starve_cnt,
    output logic             grant_if,
    output logic             grant_d
);

    logic starved;

    // Pick the winner from the two valids and the starvation state.
    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    always_comb begin
        starved  = (starve_cnt == CNT_W'(STARVE_MAX));
        grant_d  = d_valid && !(if_valid && starved);
        grant_if = if_valid && !grant_d;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store.
// One access at a time: handshake, fixed-latency access, one-cycle response.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATAW      = 32,
    parameter int ADDRW      = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    // fetch port
    input  logic             if_req_valid,
    input  logic [ADDRW-1:0] if_req_addr,
    output logic             if_req_ready,
    output logic             if_resp_valid,
    output logic [DATAW-1:0] if_resp_data,
    // load/store port
    input  logic             d_req_valid,
    input  logic             d_req_write,
    input  logic [1:0]       d_req_size,
    input  logic [ADDRW-1:0] d_req_addr,
    input  logic [DATAW-1:0] d_req_wdata,
    output logic             d_req_ready,
    output logic             d_resp_valid,
    output logic [DATAW-1:0] d_resp_data,
    // memory port
    output logic             mem_en,
    output logic             mem_rw,
    output logic [1:0]       mem_size,
    output logic [ADDRW-1:0] mem_addr,
    output logic [DATAW-1:0] mem_wdata,
    input  logic [DATAW-1:0] mem_rdata
);

    localparam int             CNT_W    = cnt_width(STARVE_MAX);
    localparam int             LAT_W    = cnt_width(MEM_LAT - 1);
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LAT - 1);

    state_t           state, state_next;
    logic [CNT_W-1:0] starve_cnt;
    logic [LAT_W-1:0] lat_cnt;
    logic             owner;
    logic             grant_if, grant_d;

    mem_arb_grant #(
        .STARVE_MAX (STARVE_MAX),
        .CNT_W      (CNT_W)
    ) u_grant (
        .if_valid   (if_req_valid),
        .d_valid    (d_req_valid),
        .starve_cnt (starve_cnt),
        .grant_if   (grant_if),
        .grant_d    (grant_d)
    );

    // Next-state and ready decode; readies only open while idle.
    always_comb begin
        state_next   = state;
        if_req_ready = 1'b0;
        d_req_ready  = 1'b0;
        unique case (state)
            IDLE: begin
                if_req_ready = grant_if;
                d_req_ready  = grant_d;
                if (grant_if || grant_d) state_next = BUSY;
            end
            BUSY:    if (lat_cnt == '0) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Starvation counter: counts data grants taken while fetch was waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (if_req_ready) begin
            starve_cnt <= '0;
        end else if (d_req_ready && if_req_valid && starve_cnt != CNT_W'(STARVE_MAX)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Request latch, memory drive, latency count and response capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner         <= OWN_IF;
            lat_cnt       <= '0;
            mem_en        <= 1'b0;
            mem_rw        <= 1'b0;
            mem_size      <= 2'b00;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            if_resp_valid <= 1'b0;
            if_resp_data  <= '0;
            d_resp_valid  <= 1'b0;
            d_resp_data   <= '0;
        end else begin
            mem_en        <= 1'b0;
            if_resp_valid <= 1'b0;
            d_resp_valid  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (if_req_ready) begin
                        owner     <= OWN_IF;
                        lat_cnt   <= LAT_INIT;
                        mem_en    <= 1'b1;
                        mem_rw    <= 1'b0;
                        mem_size  <= SIZE_W;
                        mem_addr  <= if_req_addr;
                        mem_wdata <= '0;
                    end else if (d_req_ready) begin
                        owner     <= OWN_D;
                        lat_cnt   <= LAT_INIT;
                        mem_en    <= 1'b1;
                        mem_rw    <= d_req_write;
                        mem_size  <= d_req_size;
                        mem_addr  <= d_req_addr;
                        mem_wdata <= d_req_wdata;
                    end
                end
                BUSY: begin
                    if (lat_cnt == '0) begin
                        if (owner == OWN_IF) begin
                            if_resp_valid <= 1'b1;
                            if_resp_data  <= mem_rdata;
                        end else begin
                            d_resp_valid <= 1'b1;
                            d_resp_data  <= mem_rw ? '0 : mem_rdata;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic
// against a transaction-level model (age since handshake decides every output).
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // main instance signals
    logic        if_req_valid = 1'b0, d_req_valid = 1'b0, d_req_write = 1'b0;
    logic [31:0] if_req_addr = '0, d_req_addr = '0, d_req_wdata = '0;
    logic [1:0]  d_req_size = '0;
    logic        if_req_ready, if_resp_valid, d_req_ready, d_resp_valid;
    logic [31:0] if_resp_data, d_resp_data;
    logic        mem_en, mem_rw;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    // MEM_LAT=1 instance signals
    logic        l_if_valid = 1'b0, l_d_valid = 1'b0, l_d_write = 1'b0;
    logic [31:0] l_if_addr = '0, l_d_addr = '0, l_d_wdata = '0;
    logic [1:0]  l_d_size = '0;
    logic        l_if_ready, l_if_resp_valid, l_d_ready, l_d_resp_valid;
    logic [31:0] l_if_resp_data, l_d_resp_data;
    logic        l_mem_en, l_mem_rw;
    logic [1:0]  l_mem_size;
    logic [31:0] l_mem_addr, l_mem_wdata, l_mem_rdata;

    mem_arbiter #(.DATAW(32), .ADDRW(32), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
        .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
        .d_req_valid(d_req_valid), .d_req_write(d_req_write), .d_req_size(d_req_size),
        .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata), .d_req_ready(d_req_ready),
        .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data),
        .mem_en(mem_en), .mem_rw(mem_rw), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.DATAW(32), .ADDRW(32), .MEM_LAT(1), .STARVE_MAX(STARVE_MAX)) dut_lat1 (
        .clk(clk), .rst_n(rst_n),
        .if_req_valid(l_if_valid), .if_req_addr(l_if_addr), .if_req_ready(l_if_ready),
        .if_resp_valid(l_if_resp_valid), .if_resp_data(l_if_resp_data),
        .d_req_valid(l_d_valid), .d_req_write(l_d_write), .d_req_size(l_d_size),
        .d_req_addr(l_d_addr), .d_req_wdata(l_d_wdata), .d_req_ready(l_d_ready),
        .d_resp_valid(l_d_resp_valid), .d_resp_data(l_d_resp_data),
        .mem_en(l_mem_en), .mem_rw(l_mem_rw), .mem_size(l_mem_size), .mem_addr(l_mem_addr),
        .mem_wdata(l_mem_wdata), .mem_rdata(l_mem_rdata)
    );

    // Memory contents as a pure function of address.
    function automatic logic [31:0] mem_func(input logic [31:0] a);
        if (a == 32'h0100_0000) return 32'h0000_0013;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    // Memory model: data valid from the mem_en cycle through cycle MEM_LAT, garbage otherwise.
    int unsigned mem_age;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                            mem_age <= 0;
        else if (mem_en)                       mem_age <= 1;
        else if (mem_age != 0 && mem_age < 64) mem_age <= mem_age + 1;
        else                                   mem_age <= 0;
    end
    assign mem_rdata   = (mem_en || (mem_age >= 1 && mem_age < MEM_LAT)) ? mem_func(mem_addr)
                                                                         : 32'hBAD0_BAD0;
    assign l_mem_rdata = l_mem_en ? mem_func(l_mem_addr) : 32'hBAD0_BAD0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Requester state: a pending request is held on the inputs until granted.
    logic        if_pend = 1'b0, d_pend = 1'b0;
    logic [31:0] if_a, d_a, d_wd;
    logic        d_w;
    logic [1:0]  d_sz;

    // Transaction model of the access in flight.
    logic        m_busy = 1'b0;
    int          m_age;
    logic        m_owner, m_rw;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata, m_exp;
    int          m_starve = 0;
    int          grant_log[$];

    // One clock cycle: drive inputs after negedge, then check this cycle's outputs.
    task automatic run_cycle();
        logic exp_gi, exp_gd, in_win, resp_cyc;
        @(negedge clk);
        if_req_valid = if_pend;
        if_req_addr  = if_pend ? if_a : $urandom();
        d_req_valid  = d_pend;
        d_req_write  = d_pend ? d_w : 1'($urandom());
        d_req_size   = d_pend ? d_sz : 2'($urandom());
        d_req_addr   = d_pend ? d_a : $urandom();
        d_req_wdata  = d_pend ? d_wd : $urandom();
        #1;
        if (m_busy) begin
            m_age++;
            if (m_age == MEM_LAT + 2) m_busy = 1'b0;
        end
        exp_gi = 1'b0;
        exp_gd = 1'b0;
        if (!m_busy) begin
            if (d_pend && (!if_pend || m_starve < STARVE_MAX)) exp_gd = 1'b1;
            else if (if_pend)                                   exp_gi = 1'b1;
        end
        in_win   = m_busy && m_age >= 1 && m_age <= MEM_LAT;
        resp_cyc = m_busy && m_age == MEM_LAT + 1;
        check("if_req_ready", if_req_ready, exp_gi);
        check("d_req_ready", d_req_ready, exp_gd);
        check("mem_en", mem_en, m_busy && m_age == 1);
        if (in_win) begin
            check("mem_addr", mem_addr, m_addr);
            check("mem_rw", mem_rw, m_rw);
            check("mem_size", mem_size, m_size);
            check("mem_wdata", mem_wdata, m_wdata);
        end
        check("if_resp_valid", if_resp_valid, resp_cyc && m_owner == OWN_IF);
        check("d_resp_valid", d_resp_valid, resp_cyc && m_owner == OWN_D);
        if (resp_cyc && m_owner == OWN_IF) check("if_resp_data", if_resp_data, m_exp);
        if (resp_cyc && m_owner == OWN_D)  check("d_resp_data", d_resp_data, m_exp);
        if (exp_gd) begin
            m_busy = 1'b1; m_age = 0; m_owner = OWN_D;
            m_rw = d_w; m_size = d_sz; m_addr = d_a; m_wdata = d_wd;
            m_exp = d_w ? 32'h0 : mem_func(d_a);
            if (if_pend && m_starve < STARVE_MAX) m_starve++;
            d_pend = 1'b0;
            grant_log.push_back(OWN_D);
        end else if (exp_gi) begin
            m_busy = 1'b1; m_age = 0; m_owner = OWN_IF;
            m_rw = 1'b0; m_size = SIZE_W; m_addr = if_a; m_wdata = 32'h0;
            m_exp = mem_func(if_a);
            m_starve = 0;
            if_pend = 1'b0;
            grant_log.push_back(OWN_IF);
        end
    endtask

    task automatic run_until_idle(input int budget);
        int k = 0;
        while ((if_pend || d_pend || m_busy) && k < budget) begin
            run_cycle();
            k++;
        end
        if (if_pend || d_pend || m_busy) check("drain_timeout", 32'd0, 32'd1);
    endtask

    task automatic new_data(input logic w, input logic [1:0] sz, input logic [31:0] a,
                            input logic [31:0] wd);
        d_pend = 1'b1; d_w = w; d_sz = sz; d_a = a; d_wd = wd;
    endtask

    initial begin
        int n_d;
        logic found;
        // reset state, checked before the first release
        #3;
        check("rst_if_ready", if_req_ready, 0);
        check("rst_d_ready", d_req_ready, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_size", mem_size, 0);
        check("rst_if_resp", {if_resp_valid, if_resp_data[30:0]}, 0);
        check("rst_d_resp", {d_resp_valid, d_resp_data[30:0]}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // fetch only
        if_pend = 1'b1; if_a = 32'h0100_0000;
        run_until_idle(20);

        // simultaneous requests with starve_cnt at 0
        grant_log.delete();
        if_pend = 1'b1; if_a = 32'h0100_0010;
        new_data(1'b0, SIZE_W, 32'h0100_0800, 32'h0);
        run_until_idle(30);
        check("simul_order_len", grant_log.size(), 2);
        if (grant_log.size() == 2) begin
            check("simul_first_d", grant_log[0], OWN_D);
            check("simul_then_if", grant_log[1], OWN_IF);
        end

        // starvation: data kept valid, fetch waits
        grant_log.delete();
        if_pend = 1'b1; if_a = 32'h0100_0020;
        for (int k = 0; k < 80 && if_pend; k++) begin
            if (!d_pend) new_data(1'($urandom()), 2'($urandom_range(0, 2)),
                                  32'h0100_1000 + 32'($urandom_range(0, 255)), $urandom());
            run_cycle();
        end
        n_d = 0;
        found = 1'b0;
        foreach (grant_log[i]) begin
            if (!found && grant_log[i] == OWN_IF) found = 1'b1;
            else if (!found) n_d++;
        end
        check("starve_fetch_granted", found, 1);
        check("starve_data_grants", n_d, STARVE_MAX);
        run_until_idle(30);

        // byte store
        new_data(1'b1, SIZE_B, 32'h0100_0104, 32'h0000_00AB);
        run_until_idle(20);

        // reset during cycle 1 of a load
        new_data(1'b0, SIZE_W, 32'h0100_0400, 32'h0);
        run_cycle();
        run_cycle();
        #1 rst_n = 1'b0;
        #1;
        check("arst_mem_en", mem_en, 0);
        check("arst_mem_rw", mem_rw, 0);
        check("arst_mem_size", mem_size, 0);
        check("arst_mem_addr", mem_addr, 0);
        check("arst_mem_wdata", mem_wdata, 0);
        check("arst_resp_valid", {if_resp_valid, d_resp_valid}, 0);
        check("arst_resp_data", if_resp_data | d_resp_data, 0);
        m_busy = 1'b0; m_starve = 0; if_pend = 1'b0; d_pend = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) run_cycle();
        if_pend = 1'b1; if_a = 32'h0100_0040;
        run_until_idle(20);

        // random traffic
        for (int k = 0; k < 600; k++) begin
            if (!if_pend && $urandom_range(0, 2) == 0)
                begin if_pend = 1'b1; if_a = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}; end
            if (!d_pend && $urandom_range(0, 1) == 0)
                new_data(1'($urandom()), 2'($urandom_range(0, 2)), $urandom(), $urandom());
            run_cycle();
        end
        run_until_idle(40);

        // MEM_LAT=1 instance: fetch answered in cycle 2
        @(negedge clk);
        l_if_valid = 1'b1; l_if_addr = 32'h0100_0200;
        #1 check("lat1_ready", l_if_ready, 1);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            l_if_valid = 1'b0;
            #1;
            check("lat1_mem_en", l_mem_en, k == 1);
            check("lat1_if_resp_valid", l_if_resp_valid, k == 2);
            check("lat1_d_resp_valid", l_d_resp_valid, 0);
            if (k == 2) check("lat1_if_resp_data", l_if_resp_data, mem_func(32'h0100_0200));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-ported unified memory between the instruction-fetch requester and the load/store requester of the pipelined RV32 core. The two sources are `imemory`-style fetch and `dmemory`-style data access. The block accepts one request at a time over a valid/ready handshake, sequences the memory access over a fixed latency, and returns a one-cycle response pulse to the winning requester. Data accesses have priority, and a starvation counter guarantees forward progress for fetch.

## Interface
- DATAW, 32, data width
- ADDRW, 32, address width
- MEM_LAT, 2, cycles from the mem_en cycle to the last cycle mem_rdata must be held valid; legal range is 1 or greater
- STARVE_MAX, 4, consecutive data grants allowed while fetch waits
- clock  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-low reset
- if_req_valid  input  1  fetch request
- if_req_addr  input  ADDRW  fetch address (word access)
- if_req_ready  output  1  fetch request accepted this cycle
- if_resp_valid  output  1  fetch data valid (one-cycle pulse)
- if_resp_data  output  DATAW  fetched instruction
- d_req_valid  input  1  data request
- d_req_write  input  1  1 = store, 0 = load
- d_req_size  input  2  00 byte, 01 half, 10 word (funct3[1:0])
- d_req_addr  input  ADDRW  data address
- d_req_wdata  input  DATAW  store data
- d_req_ready  output  1  data request accepted this cycle
- d_resp_valid  output  1  data access complete (one-cycle pulse)
- d_resp_data  output  DATAW  load data; 0 for stores
- mem_en  output  1  memory access strobe
- mem_rw  output  1  1 = write
- mem_size  output  2  access size
- mem_addr  output  ADDRW  memory address
- mem_wdata  output  DATAW  memory write data
- mem_rdata  input  DATAW  memory read data

## Operation
- FSM states: IDLE, BUSY, RESP.
- **IDLE**: grant is combinational from the valid inputs.
  - d_req_valid only: grant data.
  - if_req_valid only: grant fetch.
  - Both valid: grant data unless starve_cnt == STARVE_MAX, in which case grant fetch.
  - Exactly one of the two ready signals is high, and only for the granted requester.
  - Handshake (valid && ready): latch the request fields and owner ID, load lat_cnt = MEM_LAT-1, and go to BUSY.
- **BUSY**:
  - mem_en=1 in the first BUSY cycle only.
  - mem_addr, mem_rw, mem_size and mem_wdata are driven from the latched registers for the whole of BUSY.
  - lat_cnt decrements each cycle. When lat_cnt == 0, capture mem_rdata (loads/fetch) or 0 (stores) and go to RESP.
- **RESP**: pulse the owner's resp_valid with the captured data for one cycle, then go to IDLE. No response backpressure; the requester must accept the pulse.
- **starve_cnt** (width $clog2(STARVE_MAX+1)):
  - Increments, saturating, on a data grant while if_req_valid=1.
  - Clears on a fetch grant.
  - Holds otherwise.
- Fetch requests always have mem_rw=0 and mem_size=10.
- Both ready signals are 0 in BUSY and RESP. A requester holds valid and its fields stable until ready.

## Timing
- Reset (reset=0, asynchronous) sets:
  - state=IDLE, starve_cnt=0, lat_cnt=0.
  - mem_en=0, mem_rw=0, mem_size=0, mem_addr=0, mem_wdata=0.
  - Both resp_valid=0 and both resp_data=0.
  - Ready outputs are combinational from valid while in IDLE.
- Reset mid-access drops the in-flight request. No response is ever issued for it.
- Latency, counting the handshake cycle as cycle 0:
  - mem_en in cycle 1.
  - mem_rdata sampled at the end of cycle MEM_LAT.
  - resp_valid in cycle MEM_LAT+1.
  - Next handshake possible in cycle MEM_LAT+2.
- Throughput: one access per MEM_LAT+2 cycles.
- Requests deasserted before ready are ignored. Nothing is queued.

## Structure
- Shared package `mem_arb_pkg`:
  - state enum {IDLE, BUSY, RESP}.
  - owner constants OWN_IF=0, OWN_D=1.
  - size constants SIZE_B=2'b00, SIZE_H=2'b01, SIZE_W=2'b10.
- One sub-module, `mem_arb_grant`: the combinational priority/starvation picker. Inputs are the two valid signals, starve_cnt and STARVE_MAX; outputs are grant_if and grant_d, one-hot or zero.
- Top level holds the FSM, counters and request/response registers.

## Test plan
- **Fetch only**: if_req_addr=0x01000000 and memory returns 0x00000013.
  - Required: mem_en high for exactly cycle 1; if_resp_valid in cycle 3 with 0x00000013; d_resp_valid stays 0.
- **Simultaneous requests, starve_cnt=0**:
  - Required: d_req_ready=1 and if_req_ready=0.
  - The data response arrives first, then the fetch is granted at its next IDLE.
- **Starvation**: d_req_valid and if_req_valid both held high.
  - Required: 4 data grants, then the 5th grant goes to fetch; starve_cnt returns to 0.
- **Byte store**: addr 0x01000104, wdata 0x000000AB, size 00.
  - Required: in cycle 1, mem_rw=1, mem_size=00, mem_addr=0x01000104; d_resp_valid pulses with d_resp_data=0.
- **Reset in BUSY** (cycle 1 of a load):
  - Required: all outputs drop to 0 asynchronously and no resp_valid ever follows.
  - After release, a new fetch completes normally.
- **MEM_LAT=1 build**: fetch request.
  - Required: if_resp_valid in cycle 2 with the data presented in cycle 1.
